// File: rtl/rom_arbiter_pkg.sv
// Shared types and helpers for the ROM arbiter: FSM states, grant encoding,
// default SDRAM bases and the CPU ROM offset translation.
package rom_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_SND = 1'b1
   } grant_t;

   localparam logic [24:0] ROM0_BASE_DEF = 25'h000000;
   localparam logic [24:0] ROM1_BASE_DEF = 25'h010000;
   localparam logic [24:0] SND_BASE_DEF  = 25'h020000;

   // a is the CPU word address a[19:1]; a[18:15] therefore holds a[19:16].
   function automatic logic [15:0] cpu_rom_offset(input logic [18:0] a, input logic rom1_ce);
      if (rom1_ce && (a[18:15] == 4'hF))
         return {1'b1, a[14:0]};
      return a[15:0];
   endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the last winner loses a tie. The history bit
// only advances when upd_en marks a grant as actually taken.
module rr_arb2
   import rom_arbiter_pkg::*;
(
   input  logic   clk_sys,
   input  logic   reset,
   input  logic   req_cpu,
   input  logic   req_snd,
   input  logic   upd_en,
   output grant_t grant
);

   grant_t last_grant_q;
   grant_t last_grant_d;

   always_comb begin
      grant = GNT_CPU;
      if (req_cpu && req_snd)
         grant = (last_grant_q == GNT_SND) ? GNT_CPU : GNT_SND;
      else if (req_snd)
         grant = GNT_SND;

      last_grant_d = last_grant_q;
      if (upd_en)
         last_grant_d = grant;
   end

   // Resetting to sound lets the CPU win the first tie.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         last_grant_q <= GNT_SND;
      else
         last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the SDRAM read port between CPU ROM fetches and sound ROM reads, with a
// one-entry CPU hit register so repeated CPU reads of one word need no access.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter logic [24:0] ROM0_BASE = ROM0_BASE_DEF,
   parameter logic [24:0] ROM1_BASE = ROM1_BASE_DEF,
   parameter logic [24:0] SND_BASE  = SND_BASE_DEF
)(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic [18:0] cpu_a,
   input  logic        rom0_ce,
   input  logic        rom1_ce,
   output logic        cpu_ready,
   output logic [15:0] cpu_dout,
   input  logic        snd_req,
   input  logic [14:0] snd_a,
   output logic        snd_ack,
   output logic [15:0] snd_dout,
   output logic        sdr_req,
   output logic [24:0] sdr_addr,
   input  logic        sdr_ack,
   input  logic [15:0] sdr_data
);

   arb_state_t  state_q, state_d;
   grant_t      grant_q, grant_d;
   logic        sdr_req_q, sdr_req_d;
   logic [24:0] sdr_addr_q, sdr_addr_d;
   logic        snd_ack_q, snd_ack_d;
   logic [15:0] snd_dout_q, snd_dout_d;
   logic        hit_vld_q, hit_vld_d;
   logic [24:0] hit_addr_q, hit_addr_d;
   logic [15:0] hit_data_q, hit_data_d;

   logic        cpu_req, cpu_hit, cpu_miss, arb_upd;
   logic [24:0] cpu_addr, snd_addr;
   grant_t      arb_grant;

   always_comb begin
      cpu_req  = cpu_rd & (rom0_ce | rom1_ce);
      cpu_addr = (rom1_ce ? ROM1_BASE : ROM0_BASE) + {9'd0, cpu_rom_offset(cpu_a, rom1_ce)};
      snd_addr = SND_BASE + {10'd0, snd_a};
      cpu_hit  = cpu_req & hit_vld_q & (hit_addr_q == cpu_addr);
      cpu_miss = cpu_req & ~cpu_hit;
      arb_upd  = (state_q == IDLE) & (cpu_miss | snd_req);
   end

   rr_arb2 u_rr (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req_cpu (cpu_miss),
      .req_snd (snd_req),
      .upd_en  (arb_upd),
      .grant   (arb_grant)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sdr_req_d  = sdr_req_q;
      sdr_addr_d = sdr_addr_q;
      snd_ack_d  = 1'b0;
      snd_dout_d = snd_dout_q;
      hit_vld_d  = hit_vld_q;
      hit_addr_d = hit_addr_q;
      hit_data_d = hit_data_q;
      unique case (state_q)
         IDLE: begin
            if (arb_upd) begin
               state_d    = ISSUE;
               grant_d    = arb_grant;
               sdr_req_d  = 1'b1;
               sdr_addr_d = (arb_grant == GNT_CPU) ? cpu_addr : snd_addr;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (sdr_ack) begin
               state_d   = DONE;
               sdr_req_d = 1'b0;
               // CPU data always refills the hit register, even if cpu_rd has dropped.
               if (grant_q == GNT_CPU) begin
                  hit_vld_d  = 1'b1;
                  hit_addr_d = sdr_addr_q;
                  hit_data_d = sdr_data;
               end else begin
                  snd_dout_d = sdr_data;
                  snd_ack_d  = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= GNT_CPU;
         sdr_req_q  <= 1'b0;
         sdr_addr_q <= '0;
         snd_ack_q  <= 1'b0;
         snd_dout_q <= '0;
         hit_vld_q  <= 1'b0;
         hit_addr_q <= '0;
         hit_data_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sdr_req_q  <= sdr_req_d;
         sdr_addr_q <= sdr_addr_d;
         snd_ack_q  <= snd_ack_d;
         snd_dout_q <= snd_dout_d;
         hit_vld_q  <= hit_vld_d;
         hit_addr_q <= hit_addr_d;
         hit_data_q <= hit_data_d;
      end
   end

   // Ready is combinational so a miss stalls the CPU in its very first cycle.
   assign cpu_ready = ~cpu_miss;
   assign cpu_dout  = hit_data_q;
   assign snd_ack   = snd_ack_q;
   assign snd_dout  = snd_dout_q;
   assign sdr_req   = sdr_req_q;
   assign sdr_addr  = sdr_addr_q;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single SDRAM read port between V30 program fetches and sound-CPU ROM reads. Takes the decoded `rom0_ce`/`rom1_ce` selects and CPU address, translates them to SDRAM word addresses, and arbitrates round-robin against the sound requester. Returns data and a wait-state `cpu_ready` to the CPU bus logic. A one-entry CPU hit register avoids re-fetching the same word. Sits between the address-decode PAL logic and the SDRAM controller.

## Interface
- `ROM0_BASE`, default 25'h000000: SDRAM word base of ROM0 (128 KB).
- `ROM1_BASE`, default 25'h010000: SDRAM word base of ROM1 (128 KB).
- `SND_BASE`, default 25'h020000: SDRAM word base of sound ROM (64 KB).
- `clk_sys  in  1`: single clock; all logic on rising edge.
- `reset  in  1`: asynchronous, active-high.
- `cpu_rd  in  1`: level; CPU read cycle active.
- `cpu_a  in  19`: CPU word address `a[19:1]`.
- `rom0_ce`, `rom1_ce  in  1 each`: decoded selects.
- `cpu_ready  out  1`: high = data valid / no wait.
- `cpu_dout  out  16`: read data.
- `snd_req  in  1`: level request from the sound side.
- `snd_a  in  15`: sound word address.
- `snd_ack  out  1`: one-cycle pulse, data valid.
- `snd_dout  out  16`: sound read data.
- `sdr_req  out  1`: held high until ack.
- `sdr_addr  out  25`: SDRAM word address.
- `sdr_ack  in  1`: one-cycle pulse.
- `sdr_data  in  16`: valid with `sdr_ack`.

## Operation
- CPU request: `cpu_rd & (rom0_ce | rom1_ce)`.
  - Offset is `a[16:1]`.
  - If `rom1_ce & a[19:16]==4'hF`, the offset is `{1'b1, a[15:1]}`.
  - Address = selected base + zero-extended offset.
- Sound address = `SND_BASE` + `snd_a`.
- Hit register holds the last CPU address plus a valid bit. A CPU request whose address matches is a hit: no SDRAM access, served from the register.
- FSM states:
  - IDLE → ISSUE when any request is pending and not a hit.
  - ISSUE: `sdr_req`=1 with the address latched. → WAIT next cycle.
  - WAIT: hold `sdr_req`/`sdr_addr` until `sdr_ack`. → DONE.
  - DONE: deliver data to the granted requester. → IDLE.
- Arbitration: round-robin via a `last_grant` bit. On a tie, the requester not granted last wins. Reset value: `last_grant` = sound, so the CPU wins first.
- A grant is fixed at IDLE→ISSUE and does not change until DONE.
- `cpu_ready` is low while a CPU miss request is pending or in flight. It is high when `cpu_rd` is low or there is no ROM select (RAM/IO pass through).
- `cpu_rd` dropping mid-access: the SDRAM cycle completes. Data still loads the hit register. `cpu_ready` is not affected.
- `sdr_ack` arriving in any state other than WAIT is ignored.
- Reset mid-access: return to IDLE, drop `sdr_req` immediately, clear the hit valid bit.
- Reset values:
  - `cpu_ready`=1, `cpu_dout`=0.
  - `snd_ack`=0, `snd_dout`=0.
  - `sdr_req`=0, `sdr_addr`=0.
  - state=IDLE.

## Timing
- The request is sampled in IDLE at edge N.
- `sdr_req` is high from N+1.
- `sdr_ack` arrives at edge M ≥ N+2.
- DONE at M+1: `cpu_dout`/`snd_dout` registered; `snd_ack` pulses for one cycle, or `cpu_ready` rises. Return to IDLE at M+2.
- CPU hit: `cpu_ready` is combinationally high in the request cycle; `cpu_dout` is the register value. Hits are served even while a sound access is in flight.
- Minimum miss latency: 4 cycles request→data. Back-to-back throughput: one access per 4+ cycles.
- `cpu_ready` deasserts combinationally on a miss request, with no cycle of false ready.

## Structure
- `rom_arbiter_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT, DONE).
  - `grant_t` (GNT_CPU, GNT_SND).
  - default base constants.
  - function `cpu_rom_offset(a, rom1_ce)`.
- Sub-module `rr_arb2`: 2-input round-robin with a `last_grant` register and an update enable. Used once; separately verifiable.

## Test plan
- Reset, then CPU reads `a`=19'h00010 with `rom0_ce`:
  - `sdr_addr`=25'h000010 at cycle 1.
  - `sdr_ack` with 16'hBEEF after 3 cycles → `cpu_dout`=BEEF, `cpu_ready` high one cycle after ack.
- CPU reads `a[19:16]`=F, `a[15:1]`=0x0004 with `rom1_ce` → `sdr_addr`=25'h018004.
- Repeat the previous CPU address → `cpu_ready` high in the same cycle, no `sdr_req`, `cpu_dout` unchanged.
- CPU and sound request together from reset:
  - CPU granted first.
  - Then sound (`sdr_addr`=SND_BASE+`snd_a`); `snd_ack` pulses exactly once.
  - Then CPU again if still requesting.
- Assert `reset` while in WAIT → `sdr_req` low same cycle. A late `sdr_ack` after release is ignored; the next CPU read misses (hit valid cleared).
- `cpu_rd` drops while in WAIT → access completes, no `snd_ack`. Re-reading the same address hits.
